// File: rtl/gs_round_sched_pkg.sv
// Shared definitions for the ROLLO-II elimination round scheduler.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package gs_round_sched_pkg;

  // Scheduler FSM encodings (3-bit codes shared with legacy tooling).
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_KICK = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef logic [2:0] sched_state_t;

  // Address-width helper; never returns less than 1 so degenerate sizes still elaborate.
  function automatic int gs_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gs_round_sched_if.sv
// Bundle of the scheduler's control, loader, elimination and memory port-b signals.
// Latency: n/a (wiring only).
// Backpressure: loader uses valid/ready; err exists only with GS_SCHED_WATCHDOG_EN.
interface gs_round_sched_if
  import gs_round_sched_pkg::*;
#(
  parameter int L  = 4,
  parameter int AW = 3
);
`ifdef GS_SCHED_WATCHDOG_EN
  logic          err;
`endif
  logic          start;
  logic          busy;
  logic          done;
  logic          ld_valid;
  logic          ld_ready;
  logic [L-1:0]  ld_data;
  logic          el_start;
  logic          el_mat_sel;
  logic          el_is_last;
  logic          el_done;
  logic [AW-1:0] el_addrb;
  logic [L-1:0]  el_doutb;
  logic          el_rwb;
  logic [AW-1:0] mem_addrb;
  logic [L-1:0]  mem_doutb;
  logic          mem_rwb;

  // Scheduler side.
  modport slave (
`ifdef GS_SCHED_WATCHDOG_EN
    output err,
`endif
    input  start, ld_valid, ld_data, el_done, el_addrb, el_doutb, el_rwb,
    output busy, done, ld_ready, el_start, el_mat_sel, el_is_last,
    output mem_addrb, mem_doutb, mem_rwb
  );

  // Environment side (decrypt FSM, loader, elimination controller, memory).
  modport master (
`ifdef GS_SCHED_WATCHDOG_EN
    input  err,
`endif
    output start, ld_valid, ld_data, el_done, el_addrb, el_doutb, el_rwb,
    input  busy, done, ld_ready, el_start, el_mat_sel, el_is_last,
    input  mem_addrb, mem_doutb, mem_rwb
  );

endinterface

// File: rtl/gs_round_sched_portb_mux.sv
// Port-b selector: elimination controller when granted, else the registered loader write.
// Latency: purely combinational.
// Backpressure: none; idle port-b drives all zeros.
module gs_portb_mux
  import gs_round_sched_pkg::*;
#(
  parameter int L  = 4,
  parameter int AW = 3
) (
  input  logic          grant,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [L-1:0]  wr_dat,
  input  logic [AW-1:0] el_addr,
  input  logic [L-1:0]  el_dat,
  input  logic          el_rw,
  output logic [AW-1:0] mem_addr,
  output logic [L-1:0]  mem_dat,
  output logic          mem_rw
);

  // Grant wins; loader path only shows through while its write strobe is up.
  always_comb begin
    mem_addr = '0;
    mem_dat  = '0;
    mem_rw   = 1'b0;
    if (grant) begin
      mem_addr = el_addr;
      mem_dat  = el_dat;
      mem_rw   = el_rw;
    end else if (wr_vld) begin
      mem_addr = wr_addr;
      mem_dat  = wr_dat;
      mem_rw   = 1'b1;
    end
  end

endmodule

// File: rtl/gs_round_sched.sv
// Round scheduler: loads rows, kicks ROUNDS elimination passes, owns port-b (watchdog: GS_SCHED_WATCHDOG_EN).
// Latency: loader row hits memory one cycle after handshake; done two cycles after the final el_done.
// Backpressure: ld_ready only in LOAD; WAIT blocks on el_done (or watchdog timeout when enabled).
module gs_round_sched
  import gs_round_sched_pkg::*;
#(
  parameter int K      = 6,
  parameter int K1     = 5,
  parameter int L      = 4,
  parameter int KEEP   = 2,
  parameter int ROUNDS = 3
`ifdef GS_SCHED_WATCHDOG_EN
  ,
  parameter int MAXCYC = 1024
`endif
) (
  input logic               clk,
  input logic               rst,
  gs_round_sched_if.slave   bus
);

  localparam int AW = gs_clog2(K);
  localparam int RW = gs_clog2(ROUNDS + 1);

  sched_state_t  state;
  logic [RW-1:0] round;
  logic [AW-1:0] waddr;
  logic [AW-1:0] wend;
  logic          mat_sel;
  logic          is_last;
  logic          done_q;
  logic          hs;
  logic          last_round;

  logic          wr_vld;
  logic [AW-1:0] wr_addr;
  logic [L-1:0]  wr_dat;

`ifdef GS_SCHED_WATCHDOG_EN
  localparam int WW = gs_clog2(MAXCYC + 1);
  logic [WW-1:0] wdcnt;
  logic          err_q;
  assign bus.err = err_q;
`endif

  assign hs           = bus.ld_valid && (state == ST_LOAD);
  assign last_round   = (round == RW'(ROUNDS - 1));
  assign bus.ld_ready = (state == ST_LOAD);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.el_start = (state == ST_KICK);
  assign bus.el_mat_sel = mat_sel;
  assign bus.el_is_last = is_last;
  assign bus.done     = done_q;

  // Schedule FSM: round/address bookkeeping and pass configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      round   <= '0;
      waddr   <= '0;
      wend    <= '0;
      mat_sel <= 1'b0;
      is_last <= 1'b0;
      done_q  <= 1'b0;
`ifdef GS_SCHED_WATCHDOG_EN
      wdcnt   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_LOAD;
            round <= '0;
            waddr <= '0;
            wend  <= AW'(K - 1);
`ifdef GS_SCHED_WATCHDOG_EN
            err_q <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (hs) begin
            waddr <= waddr + AW'(1);
            if (waddr == wend) begin
              state   <= ST_KICK;
              mat_sel <= (round != '0);
              is_last <= last_round;
            end
          end
        end
        ST_KICK: begin
          state <= ST_WAIT;
`ifdef GS_SCHED_WATCHDOG_EN
          wdcnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.el_done) begin
            if (last_round) begin
              state <= ST_FIN;
            end else begin
              round <= round + RW'(1);
              waddr <= AW'(KEEP);
              wend  <= AW'(K1 - 1);
              state <= ST_LOAD;
            end
          end
`ifdef GS_SCHED_WATCHDOG_EN
          else if (wdcnt == WW'(MAXCYC - 1)) begin
            // Pass hung: abandon the schedule without a done pulse.
            state   <= ST_IDLE;
            err_q   <= 1'b1;
            mat_sel <= 1'b0;
            is_last <= 1'b0;
          end else begin
            wdcnt <= wdcnt + WW'(1);
          end
`endif
        end
        ST_FIN: begin
          state   <= ST_IDLE;
          done_q  <= 1'b1;
          mat_sel <= 1'b0;
          is_last <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Loader write stage: one registered beat per accepted row.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld  <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else begin
      wr_vld <= hs;
      if (hs) begin
        wr_addr <= waddr;
        wr_dat  <= bus.ld_data;
      end
    end
  end

  gs_portb_mux #(
    .L  (L),
    .AW (AW)
  ) u_portb_mux (
    .grant    (state == ST_WAIT),
    .wr_vld   (wr_vld),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .el_addr  (bus.el_addrb),
    .el_dat   (bus.el_doutb),
    .el_rw    (bus.el_rwb),
    .mem_addr (bus.mem_addrb),
    .mem_dat  (bus.mem_doutb),
    .mem_rw   (bus.mem_rwb)
  );

endmodule

// File: tb/tb_gs_round_sched.sv
// Randomized scoreboard bench for gs_round_sched (watchdog test with GS_SCHED_WATCHDOG_EN).
// Latency: expected writes/kicks/done carry the cycle they must appear in.
// Backpressure: loader valid patterns: back-to-back, toggling, random.
module tb_gs_round_sched;
  import gs_round_sched_pkg::*;

  localparam int K = 6, K1 = 5, L = 4, KEEP = 2, ROUNDS = 3;
  localparam int AW = gs_clog2(K);
`ifdef GS_SCHED_WATCHDOG_EN
  localparam int MAXCYC = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gs_round_sched_if #(.L(L), .AW(AW)) bus ();

  gs_round_sched #(
    .K(K), .K1(K1), .L(L), .KEEP(KEEP), .ROUNDS(ROUNDS)
`ifdef GS_SCHED_WATCHDOG_EN
    , .MAXCYC(MAXCYC)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int addr; int dat; int cyc; } wr_t;
  typedef struct { bit ms; bit last; } kick_t;

  wr_t   wq[$];
  kick_t kq[$];
  int    dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int kick_cyc = 0;
  bit in_rst = 1'b0;
  bit el_drive = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes expected events whenever the DUT presents them.
  initial begin
    wr_t   w;
    kick_t k;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        if (bus.mem_rwb === 1'b1 && !el_drive) begin
          if (wq.size() == 0) flag("unexpected_write");
          else begin
            w = wq.pop_front();
            chk("wr_addr", bus.mem_addrb, w.addr);
            chk("wr_data", bus.mem_doutb, w.dat);
            chk("wr_cycle", cyc, w.cyc);
          end
        end
        if (bus.el_start === 1'b1) begin
          kick_cyc = cyc;
          if (kq.size() == 0) flag("unexpected_el_start");
          else begin
            k = kq.pop_front();
            chk("kick_mat_sel", bus.el_mat_sel, k.ms);
            chk("kick_is_last", bus.el_is_last, k.last);
          end
        end
        if (bus.done === 1'b1) begin
          if (dq.size() == 0) flag("unexpected_done");
          else chk("done_cycle", cyc, dq.pop_front());
          chk("busy_at_done", bus.busy, 0);
        end
      end
    end
  end

  task automatic do_reset();
    bus.start = 0; bus.ld_valid = 0; bus.el_done = 0;
    bus.el_rwb = 0; bus.el_addrb = '0; bus.el_doutb = '0;
    rst = 1'b1;
    in_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_el_start", bus.el_start, 0);
    chk("rst_mat_sel", bus.el_mat_sel, 0);
    chk("rst_is_last", bus.el_is_last, 0);
    chk("rst_mem_rwb", bus.mem_rwb, 0);
    chk("rst_mem_addrb", bus.mem_addrb, 0);
    chk("rst_mem_doutb", bus.mem_doutb, 0);
`ifdef GS_SCHED_WATCHDOG_EN
    chk("rst_err", bus.err, 0);
`endif
    tick();
    rst = 1'b0;
    wq.delete(); kq.delete(); dq.delete();
    in_rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  // Load one round's rows; mode 0 back-to-back, 1 toggling valid, 2 random valid.
  // Returns ok=0 if a reset abort was taken or the loader timed out.
  task automatic load_round(input int r, input int mode, input bit abort, output bit ok);
    int n, base, i, guard, data;
    bit v;
    n = (r == 0) ? K : (K1 - KEEP);
    base = (r == 0) ? 0 : KEEP;
    i = 0;
    guard = 0;
    ok = 1'b1;
    while (i < n) begin
      if (abort && r == 1 && i == 1) begin
        do_reset();
        ok = 1'b0;
        return;
      end
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      data = (mode == 0 && r == 0) ? (i + 1) : int'($urandom_range(0, 15));
      bus.ld_valid = v;
      bus.ld_data  = L'(data);
      bus.el_done  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("ld_ready_in_load", bus.ld_ready, 1);
      if (v && bus.ld_ready) begin
        wq.push_back('{base + i, data, cyc + 1});
        i++;
        if (i == n) kq.push_back('{r != 0, r == ROUNDS - 1});
      end
      guard++;
      if (guard > 100) begin
        flag("loader_timeout");
        ok = 1'b0;
        return;
      end
      tick();
    end
    // Rows offered outside LOAD must be ignored.
    bus.ld_valid = (mode == 2);
    bus.ld_data  = L'($urandom_range(0, 15));
    bus.el_done  = 1'b0;
  endtask

  task automatic run_sched(input int mode, input int el_gap, input bit passthru, input bit abort);
    bit ok;
    int g;
    pulse_start();
    for (int r = 0; r < ROUNDS; r++) begin
      load_round(r, mode, abort, ok);
      if (!ok) return;
      tick();  // KICK -> first WAIT cycle
      if (passthru && r == 1) begin
        el_drive = 1'b1;
        bus.el_addrb = AW'(3);
        bus.el_doutb = L'(4'hA);
        bus.el_rwb   = 1'b1;
        bus.start    = 1'b1;
        #1;
        chk("pass_addrb", bus.mem_addrb, 3);
        chk("pass_doutb", bus.mem_doutb, 4'hA);
        chk("pass_rwb", bus.mem_rwb, 1);
        tick();
        bus.start = 0; bus.el_rwb = 0; bus.el_addrb = '0; bus.el_doutb = '0;
        el_drive = 1'b0;
        chk("busy_in_wait", bus.busy, 1);
      end
      repeat (el_gap) tick();
      chk("mat_sel_hold", bus.el_mat_sel, r != 0);
      chk("is_last_hold", bus.el_is_last, r == ROUNDS - 1);
      bus.el_done = 1'b1;
      if (r == ROUNDS - 1) dq.push_back(cyc + 2);
      tick();
      bus.el_done = 1'b0;
    end
    bus.ld_valid = 1'b0;
    g = 0;
    while (bus.busy && g < 10) begin
      tick();
      g++;
    end
    chk("busy_after_sched", bus.busy, 0);
  endtask

`ifdef GS_SCHED_WATCHDOG_EN
  task automatic watchdog_test();
    bit ok;
    int g;
    pulse_start();
    load_round(0, 0, 1'b0, ok);
    bus.ld_valid = 1'b0;
    g = 0;
    while (bus.err !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("wd_err", bus.err, 1);
    chk("wd_latency", cyc - kick_cyc, MAXCYC + 1);
    chk("wd_busy", bus.busy, 0);
    repeat (4) tick();
    chk("wd_err_sticky", bus.err, 1);
    pulse_start();
    chk("wd_err_cleared", bus.err, 0);
    do_reset();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.el_done = 0;
    bus.el_addrb = '0; bus.el_doutb = '0; bus.el_rwb = 0;
    rst = 1'b1;
    do_reset();
    run_sched(0, 20, 1'b0, 1'b0);
    run_sched(1, 5, 1'b1, 1'b0);
    run_sched(1, 4, 1'b0, 1'b1);
    run_sched(0, 2, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) run_sched(2, int'($urandom_range(0, 6)), 1'b1, 1'b0);
`ifdef GS_SCHED_WATCHDOG_EN
    watchdog_test();
    run_sched(0, 1, 1'b0, 1'b0);
`endif
    repeat (5) tick();
    chk("writes_drained", wq.size(), 0);
    chk("kicks_drained", kq.size(), 0);
    chk("done_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
